// File: rtl/otter_pkg.sv
// Shared OTTER pipeline definitions.
//   pc_src_t      : EX-stage redirect select (also used by the branch condition generator).
//   fetch_state_t : IF-stage fetch controller states.
//   DEFAULT_RESET_VECTOR : PC loaded on reset unless overridden.
package otter_pkg;

    typedef enum logic [2:0] {
        PC_PLUS4  = 3'b000,
        PC_JALR   = 3'b001,
        PC_BRANCH = 3'b010,
        PC_JAL    = 3'b011,
        PC_MTVEC  = 3'b100,
        PC_MEPC   = 3'b101
    } pc_src_t;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        WAIT_REDIR,
        FLUSH
    } fetch_state_t;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

endpackage

// File: rtl/pc_next_mux.sv
// Combinational redirect target selection for the fetch controller.
// Ports:
//   pc_src_i        : EX redirect select (110/111 reserved, treated as no redirect)
//   *_target_i      : candidate redirect targets
//   pc_plus4_i      : sequential next address
//   redirect_o      : a non-sequential redirect is requested
//   target_o        : selected target with bit[0] cleared
//   misaligned_o    : selected target has bit[1] set
//   next_pc_o       : target_o on redirect, otherwise pc_plus4_i
module pc_next_mux
    import otter_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [2:0]      pc_src_i,
    input  logic [XLEN-1:0] jalr_target_i,
    input  logic [XLEN-1:0] branch_target_i,
    input  logic [XLEN-1:0] jal_target_i,
    input  logic [XLEN-1:0] mtvec_i,
    input  logic [XLEN-1:0] mepc_i,
    input  logic [XLEN-1:0] pc_plus4_i,
    output logic            redirect_o,
    output logic [XLEN-1:0] target_o,
    output logic            misaligned_o,
    output logic [XLEN-1:0] next_pc_o
);

    logic [XLEN-1:0] raw_target;

    always_comb begin
        raw_target = pc_plus4_i;
        redirect_o = 1'b0;
        case (pc_src_i)
            PC_JALR:   begin raw_target = jalr_target_i;   redirect_o = 1'b1; end
            PC_BRANCH: begin raw_target = branch_target_i; redirect_o = 1'b1; end
            PC_JAL:    begin raw_target = jal_target_i;    redirect_o = 1'b1; end
            PC_MTVEC:  begin raw_target = mtvec_i;         redirect_o = 1'b1; end
            PC_MEPC:   begin raw_target = mepc_i;          redirect_o = 1'b1; end
            default:   begin raw_target = pc_plus4_i;      redirect_o = 1'b0; end
        endcase
    end

    // Bit[0] is never part of a fetch address; bit[1] is flagged, not corrected.
    assign target_o     = raw_target & ~XLEN'(1);
    assign misaligned_o = redirect_o & raw_target[1];
    assign next_pc_o    = redirect_o ? target_o : pc_plus4_i;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// IF-stage program counter owner for the pipelined OTTER.
// Ports:
//   CLK, RST            : clock and synchronous active-high reset
//   PC_source           : EX redirect select
//   jalr_target .. mepc : candidate redirect targets
//   hazard_stall        : load-use stall, holds PC and IF/ID
//   imem_ready          : instruction memory has the word for the current PC
//   PC, PC_plus4        : current fetch address and its sequential successor
//   imem_rden           : fetch request
//   if_valid            : IF/ID may capture the fetched instruction
//   flush_ifid/idex     : squash younger instructions after a redirect
//   target_misaligned   : pulses in the cycle a bit[1]-set redirect target is presented
module pc_fetch_ctrl
    import otter_pkg::*;
#(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR)
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [2:0]      PC_source,
    input  logic [XLEN-1:0] jalr_target,
    input  logic [XLEN-1:0] branch_target,
    input  logic [XLEN-1:0] jal_target,
    input  logic [XLEN-1:0] mtvec,
    input  logic [XLEN-1:0] mepc,
    input  logic            hazard_stall,
    input  logic            imem_ready,
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] PC_plus4,
    output logic            imem_rden,
    output logic            if_valid,
    output logic            flush_ifid,
    output logic            flush_idex,
    output logic            target_misaligned
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pend_pc_q, pend_pc_d;
    logic            pend_mis_q, pend_mis_d;
    logic            mis_q, mis_d;

    logic            redirect;
    logic [XLEN-1:0] target;
    logic            target_mis;
    logic [XLEN-1:0] next_pc;

    assign PC_plus4 = pc_q + XLEN'(4);

    pc_next_mux #(
        .XLEN (XLEN)
    ) u_pc_next_mux (
        .pc_src_i        (PC_source),
        .jalr_target_i   (jalr_target),
        .branch_target_i (branch_target),
        .jal_target_i    (jal_target),
        .mtvec_i         (mtvec),
        .mepc_i          (mepc),
        .pc_plus4_i      (PC_plus4),
        .redirect_o      (redirect),
        .target_o        (target),
        .misaligned_o    (target_mis),
        .next_pc_o       (next_pc)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_pc_d  = pend_pc_q;
        pend_mis_d = pend_mis_q;
        mis_d      = 1'b0;
        imem_rden  = 1'b0;
        if_valid   = 1'b0;
        flush_ifid = 1'b0;
        flush_idex = 1'b0;

        case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                imem_rden = 1'b1;
                if (redirect) begin
                    // The redirecting instruction is older than anything stalled in ID.
                    if (imem_ready) begin
                        pc_d    = next_pc;
                        mis_d   = target_mis;
                        state_d = FLUSH;
                    end else begin
                        pend_pc_d  = target;
                        pend_mis_d = target_mis;
                        state_d    = WAIT_REDIR;
                    end
                end else if (imem_ready && !hazard_stall) begin
                    pc_d     = next_pc;
                    if_valid = 1'b1;
                end
            end
            WAIT_REDIR: begin
                // PC_source is ignored here: its producers are already being squashed.
                imem_rden = 1'b1;
                if (imem_ready) begin
                    pc_d    = pend_pc_q;
                    mis_d   = pend_mis_q;
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                imem_rden  = 1'b1;
                flush_ifid = 1'b1;
                flush_idex = 1'b1;
                if (imem_ready) begin
                    pc_d = PC_plus4;
                end
                state_d = RUN;
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= BOOT;
            pc_q       <= RESET_VECTOR;
            pend_pc_q  <= RESET_VECTOR;
            pend_mis_q <= 1'b0;
            mis_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_pc_q  <= pend_pc_d;
            pend_mis_q <= pend_mis_d;
            mis_q      <= mis_d;
        end
    end

    assign PC                = pc_q;
    assign target_misaligned = mis_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed plus randomized bench for pc_fetch_ctrl with a behavioural fetch model.
module tb_pc_fetch_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic [2:0]  PC_source;
    logic [31:0] jalr_target, branch_target, jal_target, mtvec, mepc;
    logic        hazard_stall, imem_ready;
    logic [31:0] PC, PC_plus4;
    logic        imem_rden, if_valid, flush_ifid, flush_idex, target_misaligned;

    int checks = 0;
    int errors = 0;

    // Reference model: what the fetch unit is doing this cycle.
    bit          m_known = 0;
    bit          m_boot_cycle;       // settle cycle right after reset
    bit          m_flush_cycle;      // cycle in which the redirect target is fetched
    bit          m_mis;
    logic [31:0] m_pc;
    logic [31:0] m_waiting[$];       // redirect target held while memory is busy

    pc_fetch_ctrl dut (
        .CLK               (CLK),
        .RST               (RST),
        .PC_source         (PC_source),
        .jalr_target       (jalr_target),
        .branch_target     (branch_target),
        .jal_target        (jal_target),
        .mtvec             (mtvec),
        .mepc              (mepc),
        .hazard_stall      (hazard_stall),
        .imem_ready        (imem_ready),
        .PC                (PC),
        .PC_plus4          (PC_plus4),
        .imem_rden         (imem_rden),
        .if_valid          (if_valid),
        .flush_ifid        (flush_ifid),
        .flush_idex        (flush_idex),
        .target_misaligned (target_misaligned)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] chosen_target(input logic [2:0] src);
        logic [31:0] t;
        case (src)
            3'd1:    t = jalr_target;
            3'd2:    t = branch_target;
            3'd3:    t = jal_target;
            3'd4:    t = mtvec;
            3'd5:    t = mepc;
            default: t = 32'h0;
        endcase
        return {t[31:1], 1'b0};
    endfunction

    // Compare at the falling edge, advance the model, then return just after the rising edge.
    task automatic cyc();
        bit          redir;
        logic [31:0] tgt;
        @(negedge CLK);
        redir = (PC_source >= 3'd1) && (PC_source <= 3'd5);
        tgt   = chosen_target(PC_source);
        if (m_known) begin
            check("pc",       PC,       m_pc);
            check("pc_plus4", PC_plus4, m_pc + 32'd4);
            check("rden",     {31'b0, imem_rden}, {31'b0, !m_boot_cycle});
            check("if_valid", {31'b0, if_valid},
                  {31'b0, !m_boot_cycle && !m_flush_cycle && m_waiting.size() == 0 &&
                          imem_ready && !hazard_stall && !redir});
            check("flush",    {30'b0, flush_ifid, flush_idex}, {30'b0, m_flush_cycle, m_flush_cycle});
            check("misalign", {31'b0, target_misaligned}, {31'b0, m_mis});
        end
        if (RST) begin
            m_known = 1; m_pc = 32'h0; m_boot_cycle = 1; m_flush_cycle = 0; m_mis = 0;
            m_waiting.delete();
        end else if (m_known) begin
            m_mis = 0;
            if (m_boot_cycle) begin
                m_boot_cycle = 0;
            end else if (m_flush_cycle) begin
                m_flush_cycle = 0;
                if (imem_ready) m_pc = m_pc + 32'd4;
            end else if (m_waiting.size() != 0) begin
                if (imem_ready) begin
                    m_pc = m_waiting.pop_front();
                    m_mis = m_pc[1];
                    m_flush_cycle = 1;
                end
            end else if (redir) begin
                if (imem_ready) begin
                    m_pc = tgt; m_mis = tgt[1]; m_flush_cycle = 1;
                end else begin
                    m_waiting.push_back(tgt);
                end
            end else if (imem_ready && !hazard_stall) begin
                m_pc = m_pc + 32'd4;
            end
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST = 1; PC_source = 3'd0; hazard_stall = 0; imem_ready = 1;
        jalr_target = 0; branch_target = 0; jal_target = 0; mtvec = 0; mepc = 0;

        // Reset for two cycles, boot, then sequential fetch 0,4,8,0xc.
        cyc(); cyc();
        RST = 0;
        check("boot_pc", PC, 32'h0);
        check("boot_rden", {31'b0, imem_rden}, 32'd0);
        cyc(); cyc(); cyc(); cyc(); cyc();
        check("seq_pc_10", PC, 32'h10);

        // Taken branch.
        PC_source = 3'b010; branch_target = 32'h40;
        cyc();
        PC_source = 3'b000;
        check("br_pc", PC, 32'h40);
        check("br_flush", {31'b0, flush_ifid & flush_idex}, 32'd1);
        cyc();
        check("br_next_pc", PC, 32'h44);
        check("br_flush_once", {31'b0, flush_ifid | flush_idex}, 32'd0);

        // Redirect coincident with a stall.
        hazard_stall = 1; PC_source = 3'b011; jal_target = 32'h100;
        cyc();
        hazard_stall = 0; PC_source = 3'b000;
        check("jal_stall_pc", PC, 32'h100);
        check("jal_stall_flush", {31'b0, flush_ifid}, 32'd1);
        cyc();

        // Redirect during memory wait; later select ignored; misaligned target.
        PC_source = 3'b001; jalr_target = 32'h203; imem_ready = 0;
        cyc();
        PC_source = 3'b010; branch_target = 32'h500;
        cyc(); cyc();
        check("wait_pc_held", PC, 32'h104);
        PC_source = 3'b000; imem_ready = 1;
        cyc();
        check("jalr_pc", PC, 32'h202);
        check("jalr_mis", {31'b0, target_misaligned}, 32'd1);
        cyc();
        check("jalr_mis_once", {31'b0, target_misaligned}, 32'd0);

        // Reset while waiting on a redirect.
        PC_source = 3'b001; jalr_target = 32'h300; imem_ready = 0;
        cyc();
        RST = 1; PC_source = 3'b000;
        cyc();
        RST = 0; imem_ready = 1;
        check("rst_mid_pc", PC, 32'h0);
        check("rst_mid_flush", {31'b0, flush_ifid}, 32'd0);
        check("rst_mid_boot", {31'b0, imem_rden}, 32'd0);
        cyc();

        // Wrap-around with reserved select.
        PC_source = 3'b011; jal_target = 32'hFFFF_FFF8;
        cyc();
        PC_source = 3'b000;
        cyc();
        check("wrap_pre", PC, 32'hFFFF_FFFC);
        PC_source = 3'b111;
        cyc();
        PC_source = 3'b000;
        check("wrap_pc", PC, 32'h0);
        check("wrap_flush", {31'b0, flush_ifid}, 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            RST           = ($urandom_range(0, 49) == 0);
            PC_source     = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            jalr_target   = $urandom;
            branch_target = $urandom;
            jal_target    = $urandom;
            mtvec         = $urandom;
            mepc          = $urandom;
            hazard_stall  = ($urandom_range(0, 4) == 0);
            imem_ready    = ($urandom_range(0, 3) != 0);
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
- Consumer end of the branch/jump resolution interface: takes the 3-bit PC_source select produced in EX plus the candidate targets, and owns the program counter.
- Generates the next-fetch PC, applies hazard stalls and instruction-memory wait states, and issues the IF/ID and ID/EX flushes that follow a taken redirect.
- Sits in the IF stage of the pipelined OTTER, between the EX-stage branch condition logic and instruction memory port 1.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- XLEN, 32, address width.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  synchronous, active-high reset.
- PC_source  input  3  EX redirect select: 000 PC+4, 001 jalr, 010 branch, 011 jal, 100 mtvec, 101 mepc, 110/111 reserved (treated as 000).
- jalr_target, branch_target, jal_target, mtvec, mepc  input  XLEN each  candidate targets.
- hazard_stall  input  1  load-use stall from the hazard unit; hold PC and IF/ID.
- imem_ready  input  1  instruction memory has the word for the current PC.
- PC  output  XLEN  current fetch address, driven to imem addr1.
- PC_plus4  output  XLEN  PC+4, wrap-around modulo 2^XLEN.
- imem_rden  output  1  fetch request.
- if_valid  output  1  IF/ID register may capture the fetched instruction this cycle.
- flush_ifid, flush_idex  output  1 each  squash the younger instructions.
- target_misaligned  output  1  one-cycle pulse when an applied redirect target has bit[1] set.

Behaviour:
- Reset (RST high at the clock edge): PC=RESET_VECTOR; the state machine goes to BOOT. imem_rden, if_valid, flush_ifid, flush_idex and target_misaligned are all 0. RST overrides every other input, including a pending redirect, which is discarded.
- The redirect request is PC_source != 000 and not reserved. It is sampled every cycle regardless of stall.
- Next-PC mux: selects the target for the given PC_source, with bit[0] of every target forced to 0. When no redirect is pending, the next PC is PC+4.
- States:
  - BOOT: one cycle with imem_rden=0, then go to RUN. This gives memory a settle cycle after reset.
  - RUN: imem_rden=1.
    - imem_ready=1, no stall, no redirect: PC<=PC+4 and if_valid=1.
    - hazard_stall=1, no redirect: PC is held and if_valid=0.
    - Redirect with imem_ready=1: PC<=target and go to FLUSH. The redirect wins over hazard_stall because the branch is older than the stalled instruction.
    - Redirect with imem_ready=0: latch the target into pend_pc and go to WAIT_REDIR.
    - imem_ready=0, no redirect: PC is held and if_valid=0.
  - WAIT_REDIR: imem_rden=1, if_valid=0. Further PC_source inputs are ignored because the younger instructions are already being flushed. When imem_ready=1: PC<=pend_pc and go to FLUSH.
  - FLUSH: exactly one cycle. flush_ifid=1, flush_idex=1, if_valid=0. Then go to RUN.
- target_misaligned: asserted in the same cycle the redirect PC is loaded, if target[1]=1. The PC is still loaded with the target; trap handling is downstream.
- Flush count: the redirect decision is taken in cycle N and the target is fetched in cycle N+1. Two younger instructions are squashed in total.
- Latency: PC_source to PC update is one clock. No combinational path runs from PC_source to PC.
- PC at 32'hFFFF_FFFC with sequential advance wraps to 32'h0000_0000. There is no error flag for this case.

Decomposition:
- Shared package otter_pkg holds:
  - pc_src_t enum (PC_PLUS4, PC_JALR, PC_BRANCH, PC_JAL, PC_MTVEC, PC_MEPC), also used by the branch condition generator.
  - fetch_state_t enum (BOOT, RUN, WAIT_REDIR, FLUSH).
  - RESET_VECTOR default constant.
- Sub-module pc_next_mux: purely combinational target selection, bit[0] masking and misalignment detection. The FSM and registers stay in pc_fetch_ctrl.

Test Plan:
- Reset: RST=1 for 2 cycles, then released. PC=0, imem_rden=0 for one cycle (BOOT), then PC steps 0, 4, 8 with if_valid=1 each cycle.
- Taken branch: at PC=0x10, PC_source=010, branch_target=0x40, imem_ready=1. Next cycle PC=0x40 with flush_ifid=flush_idex=1 for exactly one cycle. The cycle after that, PC=0x44.
- Redirect during stall: hazard_stall=1 and PC_source=011 with jal_target=0x100 in the same cycle. PC=0x100 next cycle (redirect wins), and the flush pulse is asserted.
- Memory wait: PC_source=001, jalr_target=0x203, imem_ready=0 for 3 cycles. PC is held, if_valid=0, and a new PC_source=010 arriving during the wait is ignored. When imem_ready=1, PC=0x202 and target_misaligned pulses for one cycle.
- Reset mid-redirect: RST asserted while in WAIT_REDIR. PC=RESET_VECTOR, no flush pulse, and the FSM is in BOOT.
- Wrap and reserved select: PC=0xFFFF_FFFC with PC_source=111. Next cycle PC=0x0000_0000 with no flush.
